// File: rtl/zap_wb_mem_slave_if.sv
// Wishbone B3 bus bundle between the ZAP cache/MMU master and the RAM model.
// The master drives the request side and the slave drives the response side.
interface zap_wb_mem_slave_if;
    logic        cyc;
    logic        stb;
    logic        wen;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [2:0]  cti;
    logic [31:0] rdat;
    logic        ack;

    modport master (
        output cyc, stb, wen, sel, adr, wdat, cti,
        input  rdat, ack
    );

    modport slave (
        input  cyc, stb, wen, sel, adr, wdat, cti,
        output rdat, ack
    );
endinterface

// File: rtl/zap_wb_mem_slave.sv
// Word-addressed Wishbone B3 RAM responder with programmable initial wait
// states and byte-lane writes. Define ZAP_WB_MEM_BURST_EN to compile in
// registered-feedback incrementing bursts (CTI 010 / 111); without it every
// beat is a classic cycle and the cti input is ignored.
module zap_wb_mem_slave #(
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    zap_wb_mem_slave_if.slave wb
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] WS       = 4'(WAIT_STATES);
    localparam logic [2:0] CTI_INCR = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BEAT  = 2'd2
`ifdef ZAP_WB_MEM_BURST_EN
        ,S_BURST = 2'd3
`endif
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] ptr, ptr_next;
    logic [3:0]    wcnt, wcnt_next;
    logic          wen_ff, wen_next;
    logic          ack_ff, ack_next;
    logic          ack;
    logic [AW-1:0] word_idx;
    logic [31:0]   rdat_ff;
    logic [31:0]   mem [DEPTH];
    logic          unused_ok;

    assign word_idx = wb.adr[AW+1:2];

    // Next-state, pointer and ack qualification for the bus FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_next = state;
        ptr_next   = ptr;
        wcnt_next  = wcnt;
        wen_next   = wen_ff;
        // The only input-to-output path: the registered ack window qualified by the live strobe.
        ack        = ack_ff & wb.cyc & wb.stb & ~i_reset;

        if (!wb.cyc) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wb.stb) begin
                        ptr_next   = word_idx;
                        wen_next   = wb.wen;
                        wcnt_next  = WS;
                        state_next = (WS != 4'd0) ? S_WAIT : S_BEAT;
                    end
                end
                S_WAIT: begin
                    wcnt_next = wcnt - 4'd1;
                    if (wcnt == 4'd1) begin
                        state_next = S_BEAT;
                    end
                end
                S_BEAT: begin
                    if (ack) begin
                        state_next = S_IDLE;
`ifdef ZAP_WB_MEM_BURST_EN
                        if (wb.cti == CTI_INCR) begin
                            state_next = S_BURST;
                            ptr_next   = ptr + AW'(1);
                        end
`endif
                    end
                end
`ifdef ZAP_WB_MEM_BURST_EN
                S_BURST: begin
                    if (ack) begin
                        ptr_next   = ptr + AW'(1);
                        state_next = (wb.cti == CTI_INCR) ? S_BURST : S_IDLE;
                    end
                end
`endif
                default: state_next = S_IDLE;
            endcase
        end

        ack_next = (state_next == S_BEAT);
`ifdef ZAP_WB_MEM_BURST_EN
        ack_next = ack_next | (state_next == S_BURST);
`endif
    end

    // Control registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            wcnt   <= '0;
            wen_ff <= 1'b0;
            ack_ff <= 1'b0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            wcnt   <= wcnt_next;
            wen_ff <= wen_next;
            ack_ff <= ack_next;
        end
    end

    // Byte-lane write at the current word; read data prefetched from the next word.
    always_ff @(posedge i_clk) begin
        // NOTE: the array and its read register have no reset so they map onto block RAM; contents survive i_reset.
        if (ack && wen_ff) begin
            for (int n = 0; n < 4; n++) begin
                if (wb.sel[n]) begin
                    mem[ptr][8*n +: 8] <= wb.wdat[8*n +: 8];
                end
            end
        end
        rdat_ff <= mem[ptr_next];
    end

    assign wb.ack  = ack;
    assign wb.rdat = ack ? rdat_ff : 32'h0;

    // Address bits outside the word index are ignored by design.
`ifdef ZAP_WB_MEM_BURST_EN
    assign unused_ok = ^{wb.adr[31:AW+2], wb.adr[1:0]};
`else
    assign unused_ok = ^{wb.adr[31:AW+2], wb.adr[1:0], wb.cti};
`endif
endmodule

// File: tb/tb_zap_wb_mem_slave.sv
// Self-checking bench for zap_wb_mem_slave: two instances (0 and 2 wait
// states) behind one master driver, a word model per instance and a read
// scoreboard. Expected ack cycles follow the burst/classic build.
module tb_zap_wb_mem_slave;
    localparam int DEPTH = 4096;

`ifdef ZAP_WB_MEM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dsel;
    logic        m_cyc, m_stb, m_wen;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_wdat;
    logic [2:0]  m_cti;
    logic        ack;
    logic [31:0] rdat;
    int          cyc_no = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [2][DEPTH];
    logic [31:0] beat_dat [16];
    logic [31:0] exp_q [$];

    zap_wb_mem_slave_if bus0 ();
    zap_wb_mem_slave_if bus2 ();

    assign bus0.cyc  = m_cyc & ~dsel;
    assign bus0.stb  = m_stb & ~dsel;
    assign bus2.cyc  = m_cyc & dsel;
    assign bus2.stb  = m_stb & dsel;
    assign bus0.wen  = m_wen;
    assign bus2.wen  = m_wen;
    assign bus0.sel  = m_sel;
    assign bus2.sel  = m_sel;
    assign bus0.adr  = m_adr;
    assign bus2.adr  = m_adr;
    assign bus0.wdat = m_wdat;
    assign bus2.wdat = m_wdat;
    assign bus0.cti  = m_cti;
    assign bus2.cti  = m_cti;
    assign ack  = dsel ? bus2.ack  : bus0.ack;
    assign rdat = dsel ? bus2.rdat : bus0.rdat;

    zap_wb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .wb(bus0)
    );
    zap_wb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .wb(bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_bus();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_wen = 1'b0;
        m_cti = 3'b000;
    endtask

    task automatic set_dat(input logic [31:0] base);
        for (int i = 0; i < 16; i++) beat_dat[i] = base + 32'(i);
    endtask

    task automatic drive_beat(input int start, input int b, input int len);
        int word;
        word   = (start + b) % DEPTH;
        m_adr  = {4'($urandom_range(0, 15)), 28'(word << 2)};
        m_wdat = beat_dat[b];
        m_cti  = (len == 1) ? 3'b000 : ((b == len - 1) ? 3'b111 : 3'b010);
    endtask

    // One transaction of len beats; starts and ends on a falling edge.
    // gap_after: drop stb for one cycle after that beat. abort_after: after that
    // beat, drop cyc (abort_rst=0) or pulse reset while the next beat is offered.
    task automatic run_burst(input bit d, input bit wr, input int start, input int len,
                             input logic [3:0] be, input int gap_after,
                             input int abort_after, input bit abort_rst);
        int ws, req, word;
        bit got;
        ws   = d ? 2 : 0;
        dsel = d;
        for (int b = 0; b < len; b++) begin
            word  = (start + b) % DEPTH;
            m_cyc = 1'b1;
            m_stb = 1'b1;
            m_wen = wr;
            m_sel = be;
            drive_beat(start, b, len);
            if (!wr) exp_q.push_back(model[d][word]);
            req = cyc_no;
            got = 1'b0;
            for (int w = 0; w < 40; w++) begin
                #1;
                if (ack) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) begin
                check("ack_timeout", 32'(0), 32'(1));
                if (!wr) void'(exp_q.pop_front());
                idle_bus();
                return;
            end
            check("ack_cycle", 32'(cyc_no), 32'(req + ((BURST && b > 0) ? 0 : 1 + ws)));
            if (wr) begin
                for (int n = 0; n < 4; n++)
                    if (be[n]) model[d][word][8*n +: 8] = beat_dat[b][8*n +: 8];
            end else begin
                check("rdat", rdat, exp_q.pop_front());
            end
            @(negedge clk);
            if (b == abort_after) begin
                if (abort_rst && b + 1 < len) begin
                    drive_beat(start, b + 1, len);
                    rst = 1'b1;
                    #1 check("ack_in_reset", 32'(ack), 32'(0));
                    @(negedge clk);
                    rst = 1'b0;
                    idle_bus();
                end else begin
                    idle_bus();
                    #1 check("ack_cyc_low", 32'(ack), 32'(0));
                    @(negedge clk);
                end
                #1;
                check("ack_after_abort", 32'(ack), 32'(0));
                check("dat_after_abort", rdat, 32'h0);
                @(negedge clk);
                return;
            end
            if (b == gap_after && b < len - 1) begin
                m_stb = 1'b0;
                #1;
                check("gap_ack", 32'(ack), 32'(0));
                check("gap_dat", rdat, 32'h0);
                @(negedge clk);
            end
        end
        idle_bus();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        dsel  = 1'b0;
        m_sel = 4'h0;
        m_adr = 32'h0;
        m_wdat = 32'h0;
        idle_bus();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ack0", 32'(bus0.ack), 32'(0));
        check("rst_dat0", bus0.rdat, 32'h0);
        check("rst_ack2", 32'(bus2.ack), 32'(0));
        check("rst_dat2", bus2.rdat, 32'h0);
        @(negedge clk);

        // Classic write then read of word 0x10 (byte 0x40), then a lane merge.
        beat_dat[0] = 32'hDEAD_BEEF;
        run_burst(0, 1, 'h10, 1, 4'b1111, -1, -1, 0);
        run_burst(0, 0, 'h10, 1, 4'b1111, -1, -1, 0);
        beat_dat[0] = 32'h1122_3344;
        run_burst(0, 1, 'h10, 1, 4'b0101, -1, -1, 0);
        run_burst(0, 0, 'h10, 1, 4'b1111, -1, -1, 0);
        check("lane_merge_model", model[0]['h10], 32'hDE22_BE44);

        // Two wait states: preload A0..A3 at byte 0x100, a write abandoned in WAIT, burst read.
        set_dat(32'h0000_00A0);
        run_burst(1, 1, 'h40, 4, 4'b1111, -1, -1, 0);
        dsel   = 1'b1;
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_wen  = 1'b1;
        m_sel  = 4'b1111;
        m_adr  = 32'h100;
        m_wdat = 32'h0BAD_0BAD;
        m_cti  = 3'b000;
        @(negedge clk);
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            #1 check("wait_drop_ack", 32'(ack), 32'(0));
            @(negedge clk);
        end
        run_burst(1, 0, 'h40, 4, 4'b1111, -1, -1, 0);

        // Burst write with one stb-low cycle after beat 2, then readback.
        set_dat(32'h5A5A_0000);
        run_burst(0, 1, 'h80, 4, 4'b1111, 1, -1, 0);
        run_burst(0, 0, 'h80, 4, 4'b1111, -1, -1, 0);

        // Pointer wrap from DEPTH-1 to 0.
        set_dat(32'hC0DE_0000);
        run_burst(0, 1, DEPTH - 2, 4, 4'b1111, -1, -1, 0);
        run_burst(0, 0, DEPTH - 2, 4, 4'b1111, -1, -1, 0);

        // cyc drop after beat 1, then reset pulsed on the next burst's second beat.
        set_dat(32'h1111_0000);
        run_burst(0, 1, 'h20, 4, 4'b1111, -1, -1, 0);
        set_dat(32'h5500_0000);
        run_burst(0, 1, 'h20, 4, 4'b1111, -1, 0, 0);
        set_dat(32'h6600_0000);
        run_burst(0, 1, 'h21, 4, 4'b1111, -1, 0, 1);
        run_burst(0, 0, 'h20, 4, 4'b1111, -1, -1, 0);

        // 16-beat fill, random partial-lane classic writes, 16-beat readback.
        set_dat(32'h3000_0000);
        run_burst(1, 1, 'h200, 16, 4'b1111, -1, -1, 0);
        for (int i = 0; i < 6; i++) begin
            beat_dat[0] = $urandom;
            run_burst(1, 1, 'h200 + $urandom_range(0, 15), 1, 4'($urandom_range(1, 15)), -1, -1, 0);
        end
        run_burst(1, 0, 'h200, 16, 4'b1111, -1, -1, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/zap_wb_mem_slave.md
# zap_wb_mem_slave

Wishbone B3 responder that models a word-addressed RAM behind the ZAP cache/MMU Wishbone master port. It accepts classic single-beat cycles and registered-feedback incrementing bursts (CTI 010 / 111) issued by the cache line fill, write-back and TLB walk engines. It applies byte-lane writes and returns read data with a programmable number of initial wait states. It is used as the memory model in the core testbench and as on-chip RAM in FPGA builds.

## Interface
- DEPTH, 4096: memory size in 32-bit words; power of two, ≥ 16.
- WAIT_STATES, 0: idle cycles inserted before the first ack of every cycle/burst; 0..15.
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high; clock i_clk.
- i_wb_cyc  in  1  bus cycle valid.
- i_wb_stb  in  1  strobe.
- i_wb_wen  in  1  1 = write; sampled on the first beat only.
- i_wb_sel  in  4  byte-lane enables; bit n → dat[8n+7:8n].
- i_wb_adr  in  32  byte address; word index = adr[log2(DEPTH)+1:2], other bits ignored.
- i_wb_dat  in  32  write data.
- i_wb_cti  in  3  000 classic, 010 incrementing burst, 111 end of burst; other codes are treated as 000.
- o_wb_dat  out  32  read data; valid only while o_wb_ack is 1, otherwise 0.
- o_wb_ack  out  1  beat acknowledge.

## Operation
- States: IDLE, WAIT, BEAT, BURST.
- IDLE: when cyc&stb, latch ptr = word index, latch wen, load wcnt = WAIT_STATES. Next state is WAIT if WAIT_STATES > 0, else BEAT.
- WAIT: decrement wcnt; move to BEAT when wcnt = 1. If cyc drops, return to IDLE with no ack.
- BEAT: o_wb_ack = 1 for the first beat.
  - If cti = 010, next state is BURST and ptr ← ptr+1.
  - Otherwise, next state is IDLE.
- BURST: o_wb_ack = ack_ff & i_wb_cyc & i_wb_stb (combinational qualify).
  - Each acked beat advances ptr by 1.
  - The beat acked with cti = 111 (or 000) returns the FSM to IDLE.
  - stb low with cyc high holds ptr and gives no ack; the burst resumes when stb returns.
- Write commit: on each acked beat with latched wen = 1, mem[ptr] lanes with sel = 1 ← i_wb_dat. Lanes with sel = 0 are unchanged.
- Read: o_wb_dat is registered from mem[ptr_next] on the edge entering each ack cycle and gated to 0 when ack is low.
- Address wrap: ptr is log2(DEPTH) bits and wraps from DEPTH-1 to 0.
- cyc low in any state forces IDLE next cycle. No ack and no write occur in a cycle where cyc is low.
- Read-after-write to the same word in consecutive bursts returns the new data; there is no bypass hazard because IDLE separates cycles.
- Reset: state IDLE, o_wb_ack 0, o_wb_dat 0, ptr 0, wcnt 0. Memory contents are not cleared. A write beat in the reset cycle is not committed.

## Timing
- Request first visible at cycle N (cyc&stb).
- Classic cycle: ack at N+1+WAIT_STATES, one cycle wide. The next request is sampled no earlier than N+2+WAIT_STATES, so each classic beat costs 2+WAIT_STATES cycles.
- Burst of L beats: acks at N+1+WS, N+2+WS, …, N+L+WS, back-to-back when stb stays high.
- Each stb-low cycle inside a burst adds exactly one cycle.
- Ack never precedes stb. Ack never appears in the cycle after a cyc deassertion.
- Slave outputs depend on inputs only through the ack qualify AND gate. The master's registered outputs prevent combinational loops.

## Configuration
- ZAP_WB_MEM_BURST_EN defined: BURST state and registered-feedback burst acks are compiled in, as above.
- ZAP_WB_MEM_BURST_EN undefined: the BURST state is removed and i_wb_cti is ignored. Every beat is classic: IDLE→(WAIT)→BEAT→IDLE. A 4-beat line fill with WS = 0 takes 8 cycles instead of 4. Data and write results are identical.

## Test plan
- Classic write adr 0x40, dat 0xDEADBEEF, sel 1111, then classic read 0x40 → ack at N+1 each time, read dat 0xDEADBEEF.
- Byte-lane write sel 0101 dat 0x11223344 over 0xDEADBEEF → read returns 0xDE22BE44.
- Burst read adr 0x100, cti 010,010,010,111, WS = 2, memory preloaded 0xA0..0xA3 → acks at N+3..N+6, data 0xA0, 0xA1, 0xA2, 0xA3, then IDLE.
- Burst write with stb low for one cycle after beat 2 → 5 acks-worth cycles total (4 acks, 1 gap). Readback matches all 4 words, with no duplicate write on the gap.
- Burst read starting at word DEPTH-2, 4 beats → data from words DEPTH-2, DEPTH-1, 0, 1.
- cyc drop after beat 1 of a 4-beat write, then i_reset pulsed mid-burst on a second burst → no ack the cycle after either event, ack/dat = 0, only beat 1 committed.
